gf180mcu_latbank_wr_ctrl: RTL and testbench
===========================================

// Module: gf180mcu_latbank_wr_ctrl
// PURPOSE
//  Sequences writes into a bank of DEPTH x WIDTH set-able transparent latches (E/D/SETN/Q cells).
//  Round-robin arbitrates NREQ synchronous requesters; per write: data setup, enable pulse, hold.
//  Runs a bank-wide preset (SETN low) on request. Sits between CLK-domain masters and the latch array.
// PARAMETERS
//  NREQ       4   number of requesters
//  WIDTH      8   latch word width
//  DEPTH      16  latch words; AW = $clog2(DEPTH) (localparam)
//  PULSE_CYC  2   cycles LAT_E is high per write (>=1)
//  PRESET_CYC 2   cycles LAT_SETN is low per preset (>=1)
// PORTS
//  CLK         in  1           clock, rising edge
//  RST         in  1           synchronous reset, active-high
//  REQ         in  NREQ        write request per requester, level
//  REQ_ADDR    in  NREQ*AW     word address, requester i at [i*AW +: AW]
//  REQ_DATA    in  NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//  GNT         out NREQ        one-hot, 1-cycle completion pulse
//  BUSY        out 1           high in any state other than IDLE
//  PRESET_REQ  in  1           bank preset request, level
//  PRESET_DONE out 1           1-cycle pulse at end of preset
//  LAT_E       out DEPTH       per-word latch enable
//  LAT_D       out WIDTH       shared latch data bus
//  LAT_SETN    out 1           bank set, active-low
//  LAT_Q       in  DEPTH*WIDTH latch outputs, word j at [j*WIDTH +: WIDTH]
//  RB_ERR      out 1           sticky readback mismatch flag
// BEHAVIOUR
//  Reset: LAT_E=0, LAT_D=0, LAT_SETN=1, GNT=0, BUSY=0, PRESET_DONE=0, RB_ERR=0, rr_ptr=0, state IDLE.
//  States: IDLE, SETUP, OPEN, HOLD, PRESET, RECOV (+CHECK with macro). All outputs registered.
//  IDLE: PRESET_REQ beats REQ -> PRESET. Else if |REQ: winner = first set REQ at or after rr_ptr
//   (wrapping); capture addr/data -> SETUP. No REQ -> stay.
//  SETUP (1 cyc): LAT_D=captured data, LAT_E=0. OPEN (PULSE_CYC cyc): LAT_E[addr]=1 only.
//  HOLD (1 cyc): LAT_E=0, LAT_D held; GNT[winner]=1; rr_ptr=(winner+1)%NREQ; -> IDLE.
//  Latency: REQ sampled at IDLE edge T -> GNT high in cycle T+2+PULSE_CYC; >=1 IDLE cycle between writes.
//  LAT_D keeps the last written value outside SETUP..HOLD.
//  Captured addr/data are frozen; REQ/ADDR/DATA changes after capture are ignored; REQ dropped
//   mid-write still completes and gets GNT. Requester deasserts REQ on GNT or is re-arbitrated.
//  addr >= DEPTH: no LAT_E bit asserted, sequence timing unchanged, GNT still issued.
//  PRESET: LAT_SETN=0, LAT_E=0 for PRESET_CYC cycles -> RECOV (1 cyc, SETN=1, PRESET_DONE=1) -> IDLE.
//   PRESET_REQ still high in IDLE runs another preset. PRESET_REQ during a write waits for IDLE.
//  LAT_E and LAT_SETN=0 never overlap; at most one LAT_E bit high at any time.
//  RST mid-operation: all outputs to reset values at that edge; partially written word undefined.
// CONFIGURATION
//  GF180MCU_LATBANK_WR_CTRL_READBACK_EN defined: HOLD -> CHECK (1 cyc); in CHECK compare
//   LAT_Q word[addr] to captured data, GNT moves from HOLD to CHECK (latency +1),
//   mismatch sets RB_ERR (cleared only by RST); out-of-range addr skips compare.
//  Undefined: no CHECK state, LAT_Q unused, RB_ERR tied 0.
// STRUCTURE
//  Package gf180mcu_latbank_pkg: state enum, CHECK encoding, default width/depth/cycle constants.
//  Sub-module gf180mcu_latbank_rr_arb: NREQ round-robin arbiter (req, ptr -> one-hot winner, valid).
//  Top: FSM, cycle counter ($clog2(max(PULSE_CYC,PRESET_CYC))+1 bits), capture regs, output regs.
// TESTING (NREQ=4, WIDTH=8, DEPTH=16, PULSE_CYC=2, PRESET_CYC=2)
//  Single write: REQ=0001 addr=5 data=0xA5 -> LAT_D=0xA5 T+1..T+3, LAT_E=0x0020 T+2..T+3, GNT=0001 T+4.
//  Fairness: REQ=1111 held -> GNT order 0001,0010,0100,1000,0001; one IDLE cycle between each.
//  Preset vs write: PRESET_REQ and REQ=0100 same cycle -> SETN low 2 cyc, PRESET_DONE, then write GNT=0100.
//  Range/reset: addr=15 -> LAT_E=0x8000; RST in OPEN -> LAT_E=0,BUSY=0,GNT=0 next cycle.
//  Readback (macro): LAT_Q word 3 forced 0x00 on write 0x3C to addr 3 -> RB_ERR=1 until RST.
//  Overlap checker: assert LAT_E!=0 implies LAT_SETN==1 and $onehot0(LAT_E) all cycles.

Source files
------------

// File: rtl/gf180mcu_latbank_pkg.sv
// Shared types and defaults for the GF180MCU latch-bank write controller.
// The CHECK state exists only when GF180MCU_LATBANK_WR_CTRL_READBACK_EN is defined,
// but its encoding is reserved here so every build shares the same state map.
package gf180mcu_latbank_pkg;

    localparam int DEF_NREQ       = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_PULSE_CYC  = 2;
    localparam int DEF_PRESET_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_PRESET = 3'd4,
        ST_RECOV  = 3'd5,
        ST_CHECK  = 3'd6
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gf180mcu_latbank_rr_arb.sv
// Round-robin arbiter: picks the first asserted request at or after i_ptr,
// wrapping around. Purely combinational; the caller owns the pointer.
module gf180mcu_latbank_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_valid
);

    int w_idx;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_latbank_wr_ctrl.sv
// Write sequencer for a DEPTH x WIDTH bank of set-able transparent latches.
// Each write: SETUP (drive data) -> OPEN (enable pulse) -> HOLD (data held, grant).
// A bank preset drives LAT_SETN low, then one recovery cycle.
// Optional feature macro: GF180MCU_LATBANK_WR_CTRL_READBACK_EN adds a CHECK state
// that compares the written latch word against the captured data (sticky RB_ERR).
// Handshake: REQ is a level; the controller captures addr/data when it grants in
// IDLE and pulses GNT for one cycle when the write completes. A requester that
// keeps REQ high after GNT simply competes again.
module gf180mcu_latbank_wr_ctrl
    import gf180mcu_latbank_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int PRESET_CYC = DEF_PRESET_CYC,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*AW-1:0]      REQ_ADDR,
    input  logic [NREQ*WIDTH-1:0]   REQ_DATA,
    output logic [NREQ-1:0]         GNT,
    output logic                    BUSY,
    input  logic                    PRESET_REQ,
    output logic                    PRESET_DONE,
    output logic [DEPTH-1:0]        LAT_E,
    output logic [WIDTH-1:0]        LAT_D,
    output logic                    LAT_SETN,
    input  logic [DEPTH*WIDTH-1:0]  LAT_Q,
    output logic                    RB_ERR
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(max2(PULSE_CYC, PRESET_CYC)) + 1;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_addr;
    logic [NREQ-1:0]   r_win;
    logic [PW-1:0]     r_win_idx;
    logic [PW-1:0]     r_ptr;
    logic [DEPTH-1:0]  r_lat_e;
    logic [WIDTH-1:0]  r_lat_d;
    logic              r_setn;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic              r_done;

    logic [NREQ-1:0]   w_arb_gnt;
    logic              w_arb_valid;
    logic [PW-1:0]     w_win_idx;
    logic [AW-1:0]     w_req_addr;
    logic [WIDTH-1:0]  w_req_data;
    logic [DEPTH-1:0]  w_dec;
    logic [PW-1:0]     w_ptr_next;

    gf180mcu_latbank_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req   (REQ),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    // Select the winning requester's index, address and data.
    always_comb begin
        w_win_idx  = '0;
        w_req_addr = '0;
        w_req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_win_idx  = PW'(i);
                w_req_addr = REQ_ADDR[i*AW +: AW];
                w_req_data = REQ_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot word decode; an address beyond DEPTH selects no word.
    always_comb begin
        w_dec = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_dec[j] = (int'(r_addr) == j);
        end
    end

    assign w_ptr_next = PW'((int'(r_win_idx) + 1) % NREQ);

`ifdef GF180MCU_LATBANK_WR_CTRL_READBACK_EN
    logic [WIDTH-1:0]  r_data;
    logic              r_rb_err;
    logic [WIDTH-1:0]  w_q_word;
    logic              w_in_range;

    // Pick the latch word that was just written for the readback compare.
    always_comb begin
        w_q_word   = '0;
        w_in_range = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (int'(r_addr) == j) begin
                w_q_word   = LAT_Q[j*WIDTH +: WIDTH];
                w_in_range = 1'b1;
            end
        end
    end

    assign RB_ERR = r_rb_err;
`else
    logic w_unused_lat_q;
    assign w_unused_lat_q = ^LAT_Q;
    assign RB_ERR         = 1'b0;
`endif

    // Main sequencer: every output register is updated for the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_win     <= '0;
            r_win_idx <= '0;
            r_ptr     <= '0;
            r_lat_e   <= '0;
            r_lat_d   <= '0;
            r_setn    <= 1'b1;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef GF180MCU_LATBANK_WR_CTRL_READBACK_EN
            r_data    <= '0;
            r_rb_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gnt <= '0;
                    if (PRESET_REQ) begin
                        r_state <= ST_PRESET;
                        r_setn  <= 1'b0;
                        r_lat_e <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_arb_valid) begin
                        r_state   <= ST_SETUP;
                        r_addr    <= w_req_addr;
                        r_win     <= w_arb_gnt;
                        r_win_idx <= w_win_idx;
                        r_lat_d   <= w_req_data;
                        r_busy    <= 1'b1;
`ifdef GF180MCU_LATBANK_WR_CTRL_READBACK_EN
                        r_data    <= w_req_data;
`endif
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_OPEN;
                    r_lat_e <= w_dec;
                    r_cnt   <= '0;
                end
                ST_OPEN: begin
                    if (r_cnt == CW'(PULSE_CYC - 1)) begin
                        r_state <= ST_HOLD;
                        r_lat_e <= '0;
`ifndef GF180MCU_LATBANK_WR_CTRL_READBACK_EN
                        r_gnt   <= r_win;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
`ifdef GF180MCU_LATBANK_WR_CTRL_READBACK_EN
                    r_state <= ST_CHECK;
                    r_gnt   <= r_win;
`else
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
`endif
                end
`ifdef GF180MCU_LATBANK_WR_CTRL_READBACK_EN
                ST_CHECK: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    if (w_in_range && (w_q_word != r_data)) begin
                        r_rb_err <= 1'b1;
                    end
                end
`endif
                ST_PRESET: begin
                    if (r_cnt == CW'(PRESET_CYC - 1)) begin
                        r_state <= ST_RECOV;
                        r_setn  <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RECOV: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_lat_e <= '0;
                    r_setn  <= 1'b1;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT         = r_gnt;
    assign BUSY        = r_busy;
    assign PRESET_DONE = r_done;
    assign LAT_E       = r_lat_e;
    assign LAT_D       = r_lat_d;
    assign LAT_SETN    = r_setn;

endmodule

// File: tb/tb_gf180mcu_latbank_wr_ctrl.sv
// Bench for gf180mcu_latbank_wr_ctrl: directed scenarios plus a randomized
// multi-requester run checked against a transaction-level model (round-robin
// pick over the pending set, expected latch contents) and a latch-array model.
module tb_gf180mcu_latbank_wr_ctrl;

  localparam int NREQ       = 4;
  localparam int WIDTH      = 8;
  localparam int DEPTH      = 16;
  localparam int PULSE_CYC  = 2;
  localparam int PRESET_CYC = 2;
  localparam int AW         = 4;
`ifdef GF180MCU_LATBANK_WR_CTRL_READBACK_EN
  localparam int GNT_LAT = PULSE_CYC + 3;
  localparam bit RB_ON   = 1'b1;
`else
  localparam int GNT_LAT = PULSE_CYC + 2;
  localparam bit RB_ON   = 1'b0;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [NREQ-1:0]        REQ;
  logic [NREQ*AW-1:0]     REQ_ADDR;
  logic [NREQ*WIDTH-1:0]  REQ_DATA;
  logic [NREQ-1:0]        GNT;
  logic                   BUSY;
  logic                   PRESET_REQ;
  logic                   PRESET_DONE;
  logic [DEPTH-1:0]       LAT_E;
  logic [WIDTH-1:0]       LAT_D;
  logic                   LAT_SETN;
  logic [DEPTH*WIDTH-1:0] LAT_Q;
  logic                   RB_ERR;

  int n_cmp = 0;
  int n_err = 0;

  gf180mcu_latbank_wr_ctrl #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .PULSE_CYC(PULSE_CYC), .PRESET_CYC(PRESET_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .GNT(GNT), .BUSY(BUSY), .PRESET_REQ(PRESET_REQ), .PRESET_DONE(PRESET_DONE),
    .LAT_E(LAT_E), .LAT_D(LAT_D), .LAT_SETN(LAT_SETN), .LAT_Q(LAT_Q), .RB_ERR(RB_ERR)
  );

  // edge counter and history of REQ as seen at each rising edge
  int cyc = 0;
  logic [NREQ-1:0] hist [64];
  always @(posedge CLK) begin
    hist[cyc % 64] <= REQ;
    cyc <= cyc + 1;
  end

  // latch-array model: transparent while E high, forced to ones while SETN low
  logic [WIDTH-1:0] lat_mem [DEPTH];
  bit kill_w3 = 1'b0;
  always @(negedge CLK) begin
    if (LAT_SETN === 1'b0) for (int j = 0; j < DEPTH; j++) lat_mem[j] = '1;
    for (int j = 0; j < DEPTH; j++) if (LAT_E[j] === 1'b1) lat_mem[j] = LAT_D;
  end
  always_comb begin
    for (int j = 0; j < DEPTH; j++)
      LAT_Q[j*WIDTH +: WIDTH] = (kill_w3 && j == 3) ? '0 : lat_mem[j];
  end

  // invariants on the latch interface
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      assert (!((LAT_E != '0) && (LAT_SETN !== 1'b1)))
        else $error("FAIL overlap: LAT_E=%h LAT_SETN=%b", LAT_E, LAT_SETN);
      assert ($onehot0(LAT_E))
        else $error("FAIL lat_e_onehot: LAT_E=%h", LAT_E);
    end
  end

  // driver tasks
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    REQ_ADDR[i*AW +: AW]       = a;
    REQ_DATA[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; REQ = '0; PRESET_REQ = 1'b0; REQ_ADDR = '0; REQ_DATA = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; REQ = '0; PRESET_REQ = 1'b0; REQ_ADDR = '0; REQ_DATA = '0;
    repeat (2) @(negedge CLK);
    n_cmp++; if (LAT_E !== '0) begin n_err++; $display("FAIL reset_lat_e: got %h want 0", LAT_E); end
    n_cmp++; if (LAT_D !== '0) begin n_err++; $display("FAIL reset_lat_d: got %h want 0", LAT_D); end
    n_cmp++; if (LAT_SETN !== 1'b1) begin n_err++; $display("FAIL reset_setn: got %b want 1", LAT_SETN); end
    n_cmp++; if (GNT !== '0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", GNT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (PRESET_DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", PRESET_DONE); end
    n_cmp++; if (RB_ERR !== 1'b0) begin n_err++; $display("FAIL reset_rb_err: got %b want 0", RB_ERR); end
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_single_write();
    logic [DEPTH-1:0] exp_e;
    logic [NREQ-1:0]  exp_g;
    logic             exp_b;
    do_reset();
    set_req(0, 4'd5, 8'hA5);
    REQ = 4'b0001;
    for (int p = 1; p <= GNT_LAT + 1; p++) begin
      @(negedge CLK);
      exp_e = (p >= 2 && p <= 1 + PULSE_CYC) ? (16'd1 << 5) : 16'd0;
      exp_g = (p == GNT_LAT) ? 4'b0001 : 4'b0000;
      exp_b = (p <= GNT_LAT);
      n_cmp++; if (LAT_D !== 8'hA5) begin n_err++; $display("FAIL single_lat_d p%0d: got %h want a5", p, LAT_D); end
      n_cmp++; if (LAT_E !== exp_e) begin n_err++; $display("FAIL single_lat_e p%0d: got %h want %h", p, LAT_E, exp_e); end
      n_cmp++; if (GNT !== exp_g) begin n_err++; $display("FAIL single_gnt p%0d: got %b want %b", p, GNT, exp_g); end
      n_cmp++; if (BUSY !== exp_b) begin n_err++; $display("FAIL single_busy p%0d: got %b want %b", p, BUSY, exp_b); end
      if (p == 1) begin
        REQ = '0;                 // dropped mid-write, must still complete
        set_req(0, 4'd9, 8'h11);  // changes after capture are ignored
      end
    end
    n_cmp++; if (lat_mem[5] !== 8'hA5) begin n_err++; $display("FAIL single_word5: got %h want a5", lat_mem[5]); end
  endtask

  task automatic test_fairness();
    int k, last;
    logic [NREQ-1:0] exp_g;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), WIDTH'($urandom_range(255)));
    REQ = 4'b1111;
    k = 0; last = -1;
    for (int c = 0; c < 60 && k < 5; c++) begin
      @(negedge CLK);
      if (GNT != '0) begin
        exp_g = NREQ'(1) << (k % NREQ);
        n_cmp++; if (GNT !== exp_g) begin n_err++; $display("FAIL fair_order%0d: got %b want %b", k, GNT, exp_g); end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != GNT_LAT + 1) begin n_err++; $display("FAIL fair_gap%0d: got %0d want %0d", k, cyc - last, GNT_LAT + 1); end
        end
        last = cyc;
        k++;
      end
    end
    n_cmp++; if (k != 5) begin n_err++; $display("FAIL fair_count: got %0d want 5", k); end
    REQ = '0;
    repeat (GNT_LAT + 2) @(negedge CLK);
  endtask

  task automatic test_preset_vs_write();
    int p_gnt;
    logic exp_s, exp_d;
    logic [NREQ-1:0] exp_g;
    do_reset();
    set_req(2, 4'd9, 8'h5A);
    REQ = 4'b0100;
    PRESET_REQ = 1'b1;
    p_gnt = PRESET_CYC + 2 + GNT_LAT;
    for (int p = 1; p <= p_gnt + 1; p++) begin
      @(negedge CLK);
      exp_s = !(p <= PRESET_CYC);
      exp_d = (p == PRESET_CYC + 1);
      exp_g = (p == p_gnt) ? 4'b0100 : 4'b0000;
      n_cmp++; if (LAT_SETN !== exp_s) begin n_err++; $display("FAIL pre_setn p%0d: got %b want %b", p, LAT_SETN, exp_s); end
      n_cmp++; if (PRESET_DONE !== exp_d) begin n_err++; $display("FAIL pre_done p%0d: got %b want %b", p, PRESET_DONE, exp_d); end
      n_cmp++; if (GNT !== exp_g) begin n_err++; $display("FAIL pre_gnt p%0d: got %b want %b", p, GNT, exp_g); end
      if (p == 1) PRESET_REQ = 1'b0;
      if (p == p_gnt) REQ = '0;
    end
    n_cmp++; if (lat_mem[9] !== 8'h5A) begin n_err++; $display("FAIL pre_word9: got %h want 5a", lat_mem[9]); end
    n_cmp++; if (lat_mem[0] !== 8'hFF) begin n_err++; $display("FAIL pre_word0: got %h want ff", lat_mem[0]); end
  endtask

  task automatic test_range_reset();
    do_reset();
    set_req(0, 4'd15, 8'h77);
    REQ = 4'b0001;
    repeat (2) @(negedge CLK);
    n_cmp++; if (LAT_E !== 16'h8000) begin n_err++; $display("FAIL range_lat_e: got %h want 8000", LAT_E); end
    RST = 1'b1;
    REQ = '0;
    @(negedge CLK);
    n_cmp++; if (LAT_E !== '0) begin n_err++; $display("FAIL rst_mid_lat_e: got %h want 0", LAT_E); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", BUSY); end
    n_cmp++; if (GNT !== '0) begin n_err++; $display("FAIL rst_mid_gnt: got %b want 0", GNT); end
    n_cmp++; if (LAT_SETN !== 1'b1) begin n_err++; $display("FAIL rst_mid_setn: got %b want 1", LAT_SETN); end
    RST = 1'b0;
    for (int p = 0; p < GNT_LAT + 2; p++) begin
      @(negedge CLK);
      n_cmp++; if (GNT !== '0) begin n_err++; $display("FAIL rst_mid_nognt p%0d: got %b want 0", p, GNT); end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_mem [DEPTH];
    logic [AW-1:0]    r_a [NREQ];
    logic [WIDTH-1:0] r_d [NREQ];
    logic [NREQ-1:0]  mask, exp_g;
    int m_ptr, w, last, n_gnt;
    bit done;
    do_reset();
    // preset the whole bank so the expected contents start known
    PRESET_REQ = 1'b1;
    @(negedge CLK);
    PRESET_REQ = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge CLK);
      if (PRESET_DONE === 1'b1) done = 1'b1;
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL rnd_preset_done: got timeout want pulse"); end
    for (int j = 0; j < DEPTH; j++) exp_mem[j] = '1;
    m_ptr = 0; last = -1; n_gnt = 0; done = 1'b0;
    for (int c = 0; c < 900 && !done; c++) begin
      @(negedge CLK);
      if (GNT != '0) begin
        mask = hist[(cyc - GNT_LAT) % 64];
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && mask[idx]) w = idx;
        end
        exp_g = (w < 0) ? '0 : (NREQ'(1) << w);
        n_cmp++; if (GNT !== exp_g) begin n_err++; $display("FAIL rnd_gnt%0d: got %b want %b (pending %b)", n_gnt, GNT, exp_g, mask); end
        if (last >= 0) begin
          n_cmp++; if (cyc - last < GNT_LAT + 1) begin n_err++; $display("FAIL rnd_gap%0d: got %0d want >=%0d", n_gnt, cyc - last, GNT_LAT + 1); end
        end
        if (w >= 0) begin
          exp_mem[r_a[w]] = r_d[w];
          m_ptr = (w + 1) % NREQ;
        end
        last = cyc;
        n_gnt++;
        REQ = REQ & ~GNT;
      end
      if (c < 600) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!REQ[i] && !GNT[i] && $urandom_range(3) == 0) begin
            r_a[i] = AW'($urandom_range(DEPTH - 1));
            r_d[i] = WIDTH'($urandom_range(255));
            set_req(i, r_a[i], r_d[i]);
            REQ[i] = 1'b1;
          end
        end
      end else if (REQ == '0 && BUSY === 1'b0) begin
        done = 1'b1;
      end
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL rnd_drain: got timeout (REQ=%b) want all granted", REQ); end
    n_cmp++; if (n_gnt < 40) begin n_err++; $display("FAIL rnd_gnt_count: got %0d want >=40", n_gnt); end
    for (int j = 0; j < DEPTH; j++) begin
      n_cmp++; if (lat_mem[j] !== exp_mem[j]) begin n_err++; $display("FAIL rnd_word%0d: got %h want %h", j, lat_mem[j], exp_mem[j]); end
    end
    n_cmp++; if (RB_ERR !== 1'b0) begin n_err++; $display("FAIL rnd_rb_err: got %b want 0", RB_ERR); end
  endtask

  task automatic test_readback();
    bit seen;
    do_reset();
    kill_w3 = 1'b1;
    set_req(2, 4'd3, 8'h3C);
    REQ = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (GNT != '0) seen = 1'b1;
    end
    REQ = '0;
    n_cmp++; if (GNT !== 4'b0100) begin n_err++; $display("FAIL rb_gnt: got %b want 0100", GNT); end
    n_cmp++; if (RB_ERR !== 1'b0) begin n_err++; $display("FAIL rb_before: got %b want 0", RB_ERR); end
    @(negedge CLK);
    n_cmp++; if (RB_ERR !== RB_ON) begin n_err++; $display("FAIL rb_set: got %b want %b", RB_ERR, RB_ON); end
    kill_w3 = 1'b0;
    repeat (5) @(negedge CLK);
    n_cmp++; if (RB_ERR !== RB_ON) begin n_err++; $display("FAIL rb_sticky: got %b want %b", RB_ERR, RB_ON); end
    do_reset();
    @(negedge CLK);
    n_cmp++; if (RB_ERR !== 1'b0) begin n_err++; $display("FAIL rb_cleared: got %b want 0", RB_ERR); end
  endtask

  initial begin
    RST = 1'b1; REQ = '0; PRESET_REQ = 1'b0; REQ_ADDR = '0; REQ_DATA = '0;
    test_reset();
    test_single_write();
    test_fairness();
    test_preset_vs_write();
    test_range_reset();
    test_random();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
